// File: rtl/pa_fadd_shift_align_single_pkg.sv
// Shared constants for the single-precision fadd alignment shifter.
// Sticky collection is compiled in with PA_FADD_ALIGN_STICKY_EN.
package pa_fadd_shift_align_single_pkg;

  localparam int unsigned AlignDw         = 28;  // hidden + 23 frac + G/R/S + carry
  localparam int unsigned AlignCw         = 5;
  localparam int unsigned AlignCoarseStep = 8;
  localparam int unsigned AlignFineW      = 3;   // log2(AlignCoarseStep)

endpackage

// File: rtl/pa_fadd_align_stage.sv
// Combinational right shift by a variable amount, reporting whether any set bit fell off the end.
module pa_fadd_align_stage #(
  parameter int unsigned W  = 28,
  parameter int unsigned AW = 5
) (
  input  logic [W-1:0]  data_i,
  input  logic [AW-1:0] amt_i,
  output logic [W-1:0]  data_o,
  output logic          sticky_o
);

  logic [W-1:0] lost_mask;

  always_comb begin
    lost_mask = ~({W{1'b1}} << amt_i);
    data_o    = data_i >> amt_i;
    sticky_o  = |(data_i & lost_mask);
  end

endmodule

// File: rtl/pa_fadd_shift_align_single.sv
// Two-stage pipelined right-shift aligner (coarse by 8s, then fine 0..7) with valid/ready and flush.
// Define PA_FADD_ALIGN_STICKY_EN to OR all shifted-out bits into data_out[0].
module pa_fadd_shift_align_single
  import pa_fadd_shift_align_single_pkg::*;
#(
  parameter int unsigned DW = AlignDw,
  parameter int unsigned CW = AlignCw
) (
  input  logic          cpuclk,
  input  logic          cpurst_b,
  input  logic          align_flush,
  input  logic          align_vld_in,
  output logic          align_rdy_out,
  input  logic [DW-1:0] data_in,
  input  logic [CW-1:0] shift_cnt,
  output logic          align_vld_out,
  input  logic          align_rdy_in,
  output logic [DW-1:0] data_out,
  output logic          shift_all_out
);

  logic                  s1_vld_q, s1_vld_d;
  logic                  s2_vld_q, s2_vld_d;
  logic                  s2_rdy, s1_load, s2_load;
  logic [DW-1:0]         s1_data_q, s2_data_q, s2_data_d;
  logic [AlignFineW-1:0] s1_fine_q;
  logic                  s1_all_q, s2_all_q;
  logic [CW-1:0]         coarse_amt;
  logic [DW-1:0]         coarse_data, fine_data;
  logic                  shift_all_in;

  assign coarse_amt   = {shift_cnt[CW-1:AlignFineW], {AlignFineW{1'b0}}};
  assign shift_all_in = (shift_cnt >= CW'(DW));

  assign s2_rdy        = !s2_vld_q | align_rdy_in;
  assign align_rdy_out = !s1_vld_q | s2_rdy | align_flush;
  assign s1_load       = align_vld_in & align_rdy_out & !align_flush;
  assign s2_load       = s1_vld_q & s2_rdy & !align_flush;

  assign align_vld_out = s2_vld_q;
  assign data_out      = s2_data_q;
  assign shift_all_out = s2_all_q;

`ifdef PA_FADD_ALIGN_STICKY_EN
  logic s1_stk_q, coarse_stk, fine_stk;

  pa_fadd_align_stage #(.W(DW), .AW(CW)) u_coarse (
    .data_i  (data_in),
    .amt_i   (coarse_amt),
    .data_o  (coarse_data),
    .sticky_o(coarse_stk)
  );

  pa_fadd_align_stage #(.W(DW), .AW(AlignFineW)) u_fine (
    .data_i  (s1_data_q),
    .amt_i   (s1_fine_q),
    .data_o  (fine_data),
    .sticky_o(fine_stk)
  );

  assign s2_data_d = {fine_data[DW-1:1], fine_data[0] | fine_stk | s1_stk_q};

  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      s1_stk_q <= 1'b0;
    end else if (s1_load) begin
      s1_stk_q <= coarse_stk;
    end
  end
`else
  pa_fadd_align_stage #(.W(DW), .AW(CW)) u_coarse (
    .data_i  (data_in),
    .amt_i   (coarse_amt),
    .data_o  (coarse_data),
    .sticky_o()
  );

  pa_fadd_align_stage #(.W(DW), .AW(AlignFineW)) u_fine (
    .data_i  (s1_data_q),
    .amt_i   (s1_fine_q),
    .data_o  (fine_data),
    .sticky_o()
  );

  assign s2_data_d = fine_data;
`endif

  // Flush beats any same-cycle load; a stage refills whenever its successor makes room.
  always_comb begin
    s1_vld_d = s1_vld_q;
    s2_vld_d = s2_vld_q;
    if (align_flush) begin
      s1_vld_d = 1'b0;
      s2_vld_d = 1'b0;
    end else begin
      if (align_rdy_out) s1_vld_d = align_vld_in;
      if (s2_rdy)        s2_vld_d = s1_vld_q;
    end
  end

  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
    end
  end

  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      s1_data_q <= '0;
      s1_fine_q <= '0;
      s1_all_q  <= 1'b0;
    end else if (s1_load) begin
      s1_data_q <= coarse_data;
      s1_fine_q <= shift_cnt[AlignFineW-1:0];
      s1_all_q  <= shift_all_in;
    end
  end

  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      s2_data_q <= '0;
      s2_all_q  <= 1'b0;
    end else if (s2_load) begin
      s2_data_q <= s2_data_d;
      s2_all_q  <= s1_all_q;
    end
  end

endmodule

// File: tb/tb_pa_fadd_shift_align_single.sv
// Directed bench for pa_fadd_shift_align_single, plus a short randomized scoreboard run.
module tb_pa_fadd_shift_align_single;

`ifdef PA_FADD_ALIGN_STICKY_EN
  localparam logic [27:0] StkBit = 28'd1;
`else
  localparam logic [27:0] StkBit = 28'd0;
`endif

  logic        cpuclk;
  logic        cpurst_b;
  logic        align_flush;
  logic        align_vld_in;
  logic        align_rdy_out;
  logic [27:0] data_in;
  logic [4:0]  shift_cnt;
  logic        align_vld_out;
  logic        align_rdy_in;
  logic [27:0] data_out;
  logic        shift_all_out;

  int n_checks;
  int n_errors;

  pa_fadd_shift_align_single dut (
    .cpuclk       (cpuclk),
    .cpurst_b     (cpurst_b),
    .align_flush  (align_flush),
    .align_vld_in (align_vld_in),
    .align_rdy_out(align_rdy_out),
    .data_in      (data_in),
    .shift_cnt    (shift_cnt),
    .align_vld_out(align_vld_out),
    .align_rdy_in (align_rdy_in),
    .data_out     (data_out),
    .shift_all_out(shift_all_out)
  );

  initial cpuclk = 1'b0;
  always #5 cpuclk = ~cpuclk;

  task automatic tick();
    @(posedge cpuclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] model(input logic [27:0] d, input logic [4:0] c);
    logic [27:0] sh;
    logic [27:0] lost;
    sh   = d >> c;
    lost = ~(28'hFFFFFFF << c);
    sh[0] = sh[0] | (StkBit[0] & (|(d & lost)));
    return sh;
  endfunction

  // One isolated transfer: checks 2-cycle latency, value and shift_all flag.
  task automatic send_one(input string tag, input logic [27:0] d, input logic [4:0] c,
                          input logic [27:0] exp_d, input logic exp_all);
    align_rdy_in = 1'b1;
    align_vld_in = 1'b1;
    data_in      = d;
    shift_cnt    = c;
    tick();
    align_vld_in = 1'b0;
    chk({tag, "_lat1_vld"}, 32'(align_vld_out), 32'd0);
    tick();
    chk({tag, "_vld"}, 32'(align_vld_out), 32'd1);
    chk({tag, "_data"}, 32'(data_out), 32'(exp_d));
    chk({tag, "_all"}, 32'(shift_all_out), 32'(exp_all));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [28:0] exp_q[$];
    logic [28:0] e;
    logic        held;

    n_checks     = 0;
    n_errors     = 0;
    cpurst_b     = 1'b0;
    align_flush  = 1'b0;
    align_vld_in = 1'b0;
    align_rdy_in = 1'b1;
    data_in      = '0;
    shift_cnt    = '0;
    #23;
    chk("rst_vld", 32'(align_vld_out), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_all", 32'(shift_all_out), 32'd0);
    chk("rst_rdy", 32'(align_rdy_out), 32'd1);
    cpurst_b = 1'b1;
    tick();

    send_one("sh1", 28'h8000001, 5'd1, 28'h4000000 | StkBit, 1'b0);
    send_one("sh30", 28'hFFFFFFF, 5'd30, 28'h0000000 | StkBit, 1'b1);
    send_one("sh27", 28'hFFFFFFF, 5'd27, 28'h0000001, 1'b0);
    send_one("sh28z", 28'h0000000, 5'd28, 28'h0000000, 1'b1);
    send_one("sh31", 28'h0000001, 5'd31, StkBit, 1'b1);
    send_one("sh24", 28'hF000000, 5'd24, 28'h000000F, 1'b0);
    send_one("sh9", 28'h0000480, 5'd9, 28'h0000002 | StkBit, 1'b0);
    send_one("sh0", 28'hABCDEF1, 5'd0, 28'hABCDEF1, 1'b0);

    // Back-to-back: output after edge t is the input presented before edge t-1.
    align_rdy_in = 1'b1;
    for (int t = 0; t <= 8; t++) begin
      if (t < 8) begin
        align_vld_in = 1'b1;
        data_in      = 28'h8000001;
        shift_cnt    = 5'(t);
        #1;
        chk("b2b_rdy", 32'(align_rdy_out), 32'd1);
      end else begin
        align_vld_in = 1'b0;
      end
      tick();
      if (t >= 1) begin
        chk("b2b_vld", 32'(align_vld_out), 32'd1);
        chk("b2b_data", 32'(data_out),
            32'((28'h8000000 >> (t - 1)) | ((t == 1) ? 28'd1 : StkBit)));
      end
    end
    tick();
    chk("b2b_idle", 32'(align_vld_out), 32'd0);

    // Downstream stall with three offered inputs.
    align_rdy_in = 1'b0;
    align_vld_in = 1'b1;
    data_in      = 28'h0000100;
    shift_cnt    = 5'd4;
    tick();
    chk("stall_a_lat", 32'(align_vld_out), 32'd0);
    data_in   = 28'h0003000;
    shift_cnt = 5'd8;
    #1;
    chk("stall_rdy_s2_empty", 32'(align_rdy_out), 32'd1);
    tick();
    data_in   = 28'h00F0000;
    shift_cnt = 5'd16;
    #1;
    chk("stall_rdy_full", 32'(align_rdy_out), 32'd0);
    chk("stall_hold_vld", 32'(align_vld_out), 32'd1);
    chk("stall_hold_a", 32'(data_out), 32'h0000010);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_rdy_full", 32'(align_rdy_out), 32'd0);
      chk("stall_hold_a", 32'(data_out), 32'h0000010);
    end
    align_rdy_in = 1'b1;
    #1;
    chk("stall_rdy_back", 32'(align_rdy_out), 32'd1);
    tick();
    align_vld_in = 1'b0;
    chk("stall_b_vld", 32'(align_vld_out), 32'd1);
    chk("stall_b", 32'(data_out), 32'h0000030);
    tick();
    chk("stall_c_vld", 32'(align_vld_out), 32'd1);
    chk("stall_c", 32'(data_out), 32'h000000F);
    tick();
    chk("stall_drained", 32'(align_vld_out), 32'd0);

    // Flush with both stages full and a new input offered.
    align_rdy_in = 1'b0;
    align_vld_in = 1'b1;
    data_in      = 28'h0000001;
    shift_cnt    = 5'd0;
    tick();
    data_in = 28'h0000002;
    tick();
    data_in     = 28'h0000003;
    align_flush = 1'b1;
    #1;
    chk("flush_rdy", 32'(align_rdy_out), 32'd1);
    tick();
    align_flush  = 1'b0;
    align_vld_in = 1'b0;
    align_rdy_in = 1'b1;
    chk("flush_vld0", 32'(align_vld_out), 32'd0);
    tick();
    chk("flush_vld1", 32'(align_vld_out), 32'd0);
    tick();
    chk("flush_vld2", 32'(align_vld_out), 32'd0);

    // Asynchronous reset mid-stream.
    align_vld_in = 1'b1;
    data_in      = 28'h0000F00;
    shift_cnt    = 5'd4;
    tick();
    data_in = 28'h0000ABC;
    tick();
    align_vld_in = 1'b0;
    chk("prerst_vld", 32'(align_vld_out), 32'd1);
    chk("prerst_data", 32'(data_out), 32'h00000F0);
    #2 cpurst_b = 1'b0;
    #1;
    chk("arst_vld", 32'(align_vld_out), 32'd0);
    chk("arst_rdy", 32'(align_rdy_out), 32'd1);
    #2 cpurst_b = 1'b1;
    send_one("postrst", 28'h1234560, 5'd4, 28'h0123456, 1'b0);

    // Randomized traffic with downstream stalls, scoreboarded in order.
    held = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!held) begin
        align_vld_in = ($urandom_range(0, 3) != 0);
        data_in      = 28'($urandom());
        shift_cnt    = 5'($urandom_range(0, 31));
      end
      align_rdy_in = ($urandom_range(0, 3) != 0);
      #1;
      if (align_vld_out && align_rdy_in) begin
        if (exp_q.size() == 0) begin
          chk("rand_spurious_vld", 32'(align_vld_out), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rand_data", 32'(data_out), 32'(e[27:0]));
          chk("rand_all", 32'(shift_all_out), 32'(e[28]));
        end
      end
      if (align_vld_in && align_rdy_out) exp_q.push_back({shift_cnt >= 5'd28, model(data_in, shift_cnt)});
      held = align_vld_in && !align_rdy_out;
      tick();
    end
    align_vld_in = 1'b0;
    align_rdy_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (align_vld_out) begin
        if (exp_q.size() == 0) begin
          chk("rand_spurious_vld", 32'(align_vld_out), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rand_data", 32'(data_out), 32'(e[27:0]));
          chk("rand_all", 32'(shift_all_out), 32'(e[28]));
        end
      end
      tick();
    end
    chk("rand_drain_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
